ps2_host_fifo: RTL and testbench
================================

Name: ps2_host_fifo

Overview:
- Parametrised successor PS/2 host port.
- Bidirectional single-device PS/2 link with explicit protocol FSM, received-byte FIFO with per-byte parity flag, and frame framing checks.
- Watchdog timeout on stalled frames; TX completion reported as ACK or error.
- Sits between PS/2 pad (open-drain, active-high "pull low" controls) and CPU-side I/O register block; same clock domain as CPU.

Parameters:
INHIBIT_CYCLES, 8191, clk cycles host holds PS/2 clock low before a TX start bit (>=100 us at system clock)
TIMEOUT_CYCLES, 65535, max clk cycles between device clock falling edges inside a frame before abort
FIFO_DEPTH, 8, RX FIFO entries; power of two, >=2
SYNC_STAGES, 2, synchroniser flops on ps2_clk_d / ps2_data_d (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ps2_clk_d  in  1  raw PS/2 clock pad input
ps2_data_d  in  1  raw PS/2 data pad input
ps2_clk_q  out  1  1 = drive PS/2 clock low
ps2_data_q  out  1  1 = drive PS/2 data low
tx_data  in  8  byte to send
tx_start  in  1  1-cycle request; accepted only when tx_busy=0
tx_busy  out  1  high from accepted tx_start until tx_ready/tx_error pulse
tx_ready  out  1  1-cycle pulse: device ACK received
tx_error  out  1  1-cycle pulse: no ACK or timeout during TX
rx_data  out  8  FIFO head byte (first-word fall-through)
rx_parity_err  out  1  parity flag stored with head byte
rx_valid  out  1  FIFO not empty
rx_pop  in  1  pop head; ignored when rx_valid=0
rx_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
rx_frame_err  out  1  1-cycle pulse: bad start or stop bit, byte discarded
rx_overflow  out  1  sticky: byte dropped because FIFO full
rx_ovf_clr  in  1  clears rx_overflow (set wins if same cycle)

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM=IDLE; both lines released; watchdog cleared. Reset mid-frame abandons frame with no pulses.
- Inputs pass SYNC_STAGES flops; falling edge = prev synced clk 1, current 0. All sampling/shifting uses this edge strobe.
- FSM states: IDLE, RX, INHIBIT, TX, TX_ACK.
- IDLE: tx_start -> latch tx_data, tx_busy=1, go INHIBIT. Else falling edge -> sample start bit, go RX. tx_start and falling edge in same cycle: TX wins, edge ignored.
- RX: shift 11 bits LSB-first (start, D0..D7, parity, stop).
  - After 11th edge: start must be 0 and stop must be 1, else rx_frame_err pulse and byte dropped.
  - Parity check is odd; mismatch still pushes byte with flag=1.
  - Return to IDLE.
  - tx_start is not accepted in RX (tx_busy=0 but start ignored; bench must hold off or retry).
- INHIBIT: ps2_clk_q=1 for exactly INHIBIT_CYCLES cycles. ps2_data_q=1 from last inhibit cycle onward (start bit). Then release clock, go TX.
- TX:
  - Falling edges 1..8 place D0..D7 (ps2_data_q = ~bit).
  - Edge 9 places odd parity.
  - Edge 10 releases data (stop).
  - Edge 11 -> TX_ACK.
- TX_ACK: sample synced data on the 11th edge. 0 -> tx_ready pulse; 1 -> tx_error pulse. tx_busy drops same cycle; go IDLE.
- Watchdog:
  - Counter reloads on every falling edge and on entry to RX/TX.
  - Expiry in RX: discard partial byte, no pulse, IDLE.
  - Expiry in TX/TX_ACK: release both lines, tx_error pulse, IDLE.
  - Inactive in IDLE/INHIBIT.
- FIFO entries are 9 bits {parity_err, byte}.
  - Byte visible on rx_data/rx_valid 1 cycle after the 11th edge strobe.
  - Push while full and no pop: drop, set rx_overflow.
  - Push+pop same cycle when full: both succeed, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- RX 0x1C, parity 0, stop 1 -> rx_valid=1, rx_data=0x1C, rx_parity_err=0, rx_count=1; rx_pop -> rx_valid=0.
- RX 0xA5 with parity bit 0 (wrong) -> rx_data=0xA5, rx_parity_err=1; then RX with stop bit 0 -> rx_frame_err pulse, rx_count unchanged.
- tx_start with tx_data=0xED -> ps2_clk_q high exactly INHIBIT_CYCLES cycles; device model samples bits 1,0,1,1,0,1,1,1, parity 1, stop; ACK 0 -> tx_ready pulse, tx_busy=0.
- Same TX with device data held 1 at edge 11 -> tx_error pulse; separately, stop device clock after edge 4 -> tx_error after TIMEOUT_CYCLES, both lines released.
- Send FIFO_DEPTH+1 bytes without pop -> rx_count=FIFO_DEPTH, rx_overflow=1, first byte still at head; rx_ovf_clr -> 0. Full + push + pop same cycle -> count stays FIFO_DEPTH.
- Assert rst after RX edge 5 -> outputs 0; subsequent full frame 0x29 received correctly.

Source files
------------

// File: rtl/ps2_host_fifo.sv
// PS/2 host port: bidirectional single-device link with protocol FSM, watchdog,
// and a first-word fall-through RX FIFO storing {parity_err, byte} per entry.
module ps2_host_fifo #(
  parameter int unsigned INHIBIT_CYCLES = 8191,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk_d,
  input  logic                          ps2_data_d,
  output logic                          ps2_clk_q,
  output logic                          ps2_data_q,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_start,
  output logic                          tx_busy,
  output logic                          tx_ready,
  output logic                          tx_error,
  output logic [7:0]                    rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_valid,
  input  logic                          rx_pop,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_frame_err,
  output logic                          rx_overflow,
  input  logic                          rx_ovf_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_INHIBIT,
    S_TX,
    S_TX_ACK
  } state_t;

  // Input synchronisers; reset to the idle (released, high) line level.
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_d};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_d};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  // Protocol state
  state_t          state, state_n;
  logic [3:0]      bit_cnt, bit_cnt_n;
  logic [9:0]      rx_sr, rx_sr_n;
  logic [7:0]      tx_sr, tx_sr_n;
  logic            tx_par, tx_par_n;
  logic            tx_drive, tx_drive_n;
  logic [IW-1:0]   inh_cnt, inh_cnt_n;
  logic [WW-1:0]   wd_cnt;
  logic            wd_reload;
  logic            wd_active;
  logic            wd_expired;
  logic            inh_last;
  logic [10:0]     frame;
  logic            push;
  logic [8:0]      push_word;
  logic            ready_n, error_n, ferr_n;

  assign inh_last   = (inh_cnt == IW'(INHIBIT_CYCLES - 1));
  assign wd_active  = (state == S_RX) || (state == S_TX) || (state == S_TX_ACK);
  assign wd_expired = (wd_cnt == WW'(TIMEOUT_CYCLES));
  assign frame      = {data_s, rx_sr};

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    rx_sr_n    = rx_sr;
    tx_sr_n    = tx_sr;
    tx_par_n   = tx_par;
    tx_drive_n = tx_drive;
    inh_cnt_n  = inh_cnt;
    wd_reload  = 1'b0;
    push       = 1'b0;
    push_word  = '0;
    ready_n    = 1'b0;
    error_n    = 1'b0;
    ferr_n     = 1'b0;

    unique case (state)
      S_IDLE: begin
        tx_drive_n = 1'b0;
        if (tx_start) begin
          tx_sr_n   = tx_data;
          tx_par_n  = ~^tx_data;
          inh_cnt_n = '0;
          state_n   = S_INHIBIT;
        end else if (fall) begin
          rx_sr_n   = {data_s, rx_sr[9:1]};
          bit_cnt_n = 4'd1;
          wd_reload = 1'b1;
          state_n   = S_RX;
        end
      end

      S_RX: begin
        if (fall) begin
          wd_reload = 1'b1;
          if (bit_cnt == 4'd10) begin
            state_n = S_IDLE;
            if (!frame[0] && frame[10]) begin
              push      = 1'b1;
              push_word = {~^frame[9:1], frame[8:1]};
            end else begin
              ferr_n = 1'b1;
            end
          end else begin
            rx_sr_n   = {data_s, rx_sr[9:1]};
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end else if (wd_expired) begin
          state_n = S_IDLE;
        end
      end

      S_INHIBIT: begin
        inh_cnt_n = inh_cnt + IW'(1);
        if (inh_last) begin
          tx_drive_n = 1'b1;
          bit_cnt_n  = '0;
          wd_reload  = 1'b1;
          state_n    = S_TX;
        end
      end

      // Edges 1..10 handled here; the ACK state owns edge 11 so the ACK
      // sample and the completion pulse come from the same strobe.
      S_TX: begin
        if (fall) begin
          wd_reload = 1'b1;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt < 4'd8) begin
            tx_drive_n = ~tx_sr[bit_cnt[2:0]];
          end else if (bit_cnt == 4'd8) begin
            tx_drive_n = ~tx_par;
          end else begin
            tx_drive_n = 1'b0;
            state_n    = S_TX_ACK;
          end
        end else if (wd_expired) begin
          tx_drive_n = 1'b0;
          error_n    = 1'b1;
          state_n    = S_IDLE;
        end
      end

      S_TX_ACK: begin
        tx_drive_n = 1'b0;
        if (fall) begin
          ready_n = ~data_s;
          error_n = data_s;
          state_n = S_IDLE;
        end else if (wd_expired) begin
          error_n = 1'b1;
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      tx_par       <= 1'b0;
      tx_drive     <= 1'b0;
      inh_cnt      <= '0;
      tx_ready     <= 1'b0;
      tx_error     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      rx_sr        <= rx_sr_n;
      tx_sr        <= tx_sr_n;
      tx_par       <= tx_par_n;
      tx_drive     <= tx_drive_n;
      inh_cnt      <= inh_cnt_n;
      tx_ready     <= ready_n;
      tx_error     <= error_n;
      rx_frame_err <= ferr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || wd_reload || !wd_active) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WW'(1);
    end
  end

  assign ps2_clk_q  = (state == S_INHIBIT);
  assign ps2_data_q = ((state == S_INHIBIT) && inh_last) ||
                      (((state == S_TX) || (state == S_TX_ACK)) && tx_drive);
  assign tx_busy    = (state == S_INHIBIT) || (state == S_TX) || (state == S_TX_ACK);

  // RX FIFO
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop_ok;
  logic          wr_ok;

  assign full   = (count == CW'(FIFO_DEPTH));
  assign pop_ok = rx_pop && (count != '0);
  // When full, a same-cycle pop frees the slot the push lands in.
  assign wr_ok  = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({wr_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !wr_ok) begin
        rx_overflow <= 1'b1;
      end else if (rx_ovf_clr) begin
        rx_overflow <= 1'b0;
      end
    end
  end

  assign rx_valid      = (count != '0);
  assign rx_count      = count;
  assign rx_data       = rx_valid ? mem[rd_ptr][7:0] : '0;
  assign rx_parity_err = rx_valid ? mem[rd_ptr][8]   : 1'b0;

endmodule

// File: tb/tb_ps2_host_fifo.sv
// Directed bench for ps2_host_fifo: table-driven RX frames plus hand-written
// TX, overflow, timeout and mid-frame reset sequences against a PS/2 device model.
module tb_ps2_host_fifo;

  localparam int unsigned INH   = 20;
  localparam int unsigned TMO   = 200;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SYNC  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dev_clk = 1'b1;
  logic        dev_data = 1'b1;
  logic        ps2_clk_d, ps2_data_d;
  logic        ps2_clk_q, ps2_data_q;
  logic [7:0]  tx_data = '0;
  logic        tx_start = 1'b0;
  logic        tx_busy, tx_ready, tx_error;
  logic [7:0]  rx_data;
  logic        rx_parity_err, rx_valid;
  logic        rx_pop = 1'b0;
  logic [$clog2(DEPTH):0] rx_count;
  logic        rx_frame_err, rx_overflow;
  logic        rx_ovf_clr = 1'b0;

  // Open-drain lines: either side may pull low.
  assign ps2_clk_d  = dev_clk & ~ps2_clk_q;
  assign ps2_data_d = dev_data & ~ps2_data_q;

  ps2_host_fifo #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH(DEPTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst(rst),
    .ps2_clk_d(ps2_clk_d), .ps2_data_d(ps2_data_d),
    .ps2_clk_q(ps2_clk_q), .ps2_data_q(ps2_data_q),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .tx_ready(tx_ready), .tx_error(tx_error),
    .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_valid(rx_valid),
    .rx_pop(rx_pop), .rx_count(rx_count), .rx_frame_err(rx_frame_err),
    .rx_overflow(rx_overflow), .rx_ovf_clr(rx_ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int err_cyc = 0;
  int n_ready = 0, n_error = 0, n_ferr = 0;
  logic busy_at_pulse = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_ready) begin
      n_ready++;
      busy_at_pulse = tx_busy;
    end
    if (tx_error) begin
      n_error++;
      err_cyc = cyc;
      busy_at_pulse = tx_busy;
    end
    if (rx_frame_err) n_ferr++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par,
                                           input logic start, input logic stop);
    return {stop, par, d, start};
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk) dev_data = b;
    repeat (5) @(negedge clk);
    dev_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (10) @(negedge clk);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_frame(input logic [10:0] f);
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    dev_data = 1'b1;
  endtask

  task automatic pop1();
    @(negedge clk) rx_pop = 1'b1;
    @(negedge clk) rx_pop = 1'b0;
  endtask

  // Device side of a host-to-device transfer; bit k is read on the rising
  // edge following falling edge k, the start bit before the first edge.
  task automatic device_tx(input int n_edges, input logic ack, output logic [10:0] got);
    int w;
    got = '0;
    w = 0;
    while (ps2_clk_q && w < 1000) begin
      @(negedge clk);
      w++;
    end
    repeat (10) @(negedge clk);
    got[0] = ps2_data_d;
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11) dev_data = ack;
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (10) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) got[k] = ps2_data_d;
      dev_data = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       start;
    logic       stop;
    logic       pop;
    int         exp_count;
    logic [7:0] exp_head;
    logic       exp_perr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [10:0] got;
    int n, r0, e0, f0;

    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8'h1C, 1'b0, 0};
    vecs[1] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1, 8'hA5, 1'b1, 0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1, 8'hA5, 1'b1, 1};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1, 8'hFF, 1'b0, 0};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1, 8'h80, 1'b1, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        {ps2_clk_q, ps2_data_q, tx_busy, tx_ready, tx_error, rx_valid,
         rx_parity_err, rx_frame_err, rx_overflow}, '0);
    chk("reset_count", rx_count, 0);
    chk("reset_data", rx_data, 0);

    // Table-driven RX frames
    for (int i = 0; i < 6; i++) begin
      f0 = n_ferr;
      send_frame(mk_frame(vecs[i].data, vecs[i].par, vecs[i].start, vecs[i].stop));
      chk($sformatf("v%0d_count", i), rx_count, vecs[i].exp_count);
      chk($sformatf("v%0d_valid", i), rx_valid, (vecs[i].exp_count != 0));
      chk($sformatf("v%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
      if (vecs[i].exp_count != 0) begin
        chk($sformatf("v%0d_head", i), rx_data, vecs[i].exp_head);
        chk($sformatf("v%0d_perr", i), rx_parity_err, vecs[i].exp_perr);
      end
      if (vecs[i].pop) begin
        pop1();
        chk($sformatf("v%0d_pop_count", i), rx_count, vecs[i].exp_count - 1);
      end
    end
    chk("table_empty", rx_valid, 0);

    // Overflow: DEPTH+1 bytes with no pop
    for (int b = 0; b <= DEPTH; b++) begin
      logic [7:0] d;
      d = 8'h10 + 8'(b);
      send_frame(mk_frame(d, ~^d, 1'b0, 1'b1));
    end
    chk("ovf_count", rx_count, DEPTH);
    chk("ovf_flag", rx_overflow, 1);
    chk("ovf_head", rx_data, 8'h10);
    @(negedge clk) rx_ovf_clr = 1'b1;
    @(negedge clk) rx_ovf_clr = 1'b0;
    chk("ovf_clr", rx_overflow, 0);

    // Full FIFO: push 0x15 and pop in the same cycle
    begin
      logic [10:0] f;
      f = mk_frame(8'h15, ~^(8'h15), 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) send_bit(f[i]);
      @(negedge clk) dev_data = f[10];
      repeat (5) @(negedge clk);
      dev_clk = 1'b0;
      repeat (SYNC) @(negedge clk);
      rx_pop = 1'b1;
      @(negedge clk) rx_pop = 1'b0;
      repeat (10 - SYNC - 1) @(negedge clk);
      dev_clk = 1'b1;
      repeat (5) @(negedge clk);
    end
    chk("pushpop_count", rx_count, DEPTH);
    chk("pushpop_ovf", rx_overflow, 0);
    begin
      logic [7:0] exp_q [4];
      exp_q[0] = 8'h11; exp_q[1] = 8'h12; exp_q[2] = 8'h13; exp_q[3] = 8'h15;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("drain%0d", i), rx_data, exp_q[i]);
        pop1();
      end
    end
    chk("drain_empty", rx_valid, 0);

    // TX 0xED with ACK
    r0 = n_ready; e0 = n_error;
    @(negedge clk) begin tx_data = 8'hED; tx_start = 1'b1; end
    @(negedge clk) tx_start = 1'b0;
    chk("tx_busy_start", tx_busy, 1);
    chk("inh_data_early", ps2_data_q, 0);
    n = 0;
    while (ps2_clk_q && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("inh_cycles", n, INH);
    chk("tx_start_bit", ps2_data_q, 1);
    device_tx(11, 1'b0, got);
    chk("tx_bits", got, {1'b1, 1'b1, 8'hED, 1'b0});
    chk("tx_ready_pulse", n_ready - r0, 1);
    chk("tx_ready_noerr", n_error - e0, 0);
    chk("tx_busy_at_ready", busy_at_pulse, 0);
    chk("tx_busy_done", tx_busy, 0);

    // TX with no ACK
    r0 = n_ready; e0 = n_error;
    @(negedge clk) begin tx_data = 8'hED; tx_start = 1'b1; end
    @(negedge clk) tx_start = 1'b0;
    device_tx(11, 1'b1, got);
    chk("nack_error", n_error - e0, 1);
    chk("nack_noready", n_ready - r0, 0);
    chk("nack_busy", tx_busy, 0);

    // TX stalled after edge 4
    e0 = n_error;
    @(negedge clk) begin tx_data = 8'hED; tx_start = 1'b1; end
    @(negedge clk) tx_start = 1'b0;
    device_tx(4, 1'b0, got);
    n = 0;
    while (n_error == e0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_error", n_error - e0, 1);
    chk("tmo_window", ((err_cyc - last_fall_cyc) >= TMO) &&
                      ((err_cyc - last_fall_cyc) <= TMO + SYNC + 4), 1);
    chk("tmo_lines", {ps2_clk_q, ps2_data_q, tx_busy}, 0);

    // Reset after RX edge 5
    send_frame(mk_frame(8'h5A, 1'b1, 1'b0, 1'b1));
    chk("pre_rst_count", rx_count, 1);
    begin
      logic [10:0] f;
      f = mk_frame(8'h33, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) send_bit(f[i]);
    end
    f0 = n_ferr; r0 = n_ready; e0 = n_error;
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_outputs",
        {ps2_clk_q, ps2_data_q, tx_busy, tx_ready, tx_error, rx_valid,
         rx_parity_err, rx_frame_err, rx_overflow}, '0);
    chk("midrst_count", rx_count, 0);
    chk("midrst_pulses", (n_ferr - f0) + (n_ready - r0) + (n_error - e0), 0);
    send_frame(mk_frame(8'h29, 1'b0, 1'b0, 1'b1));
    chk("post_rst_count", rx_count, 1);
    chk("post_rst_data", rx_data, 8'h29);
    chk("post_rst_perr", rx_parity_err, 0);
    chk("post_rst_ferr", n_ferr - f0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
